herald_host_frontend: RTL

Parametrised byte-serial host front end for the Herald accelerators (CORDIC, MAC and later units).
- Host side: 8-bit data bus with level write/read strobes. The block captures a command byte and a variable number of little-endian operands.
- Accelerator side: one generic valid/ready request/response handshake carries the operands out and the result back. The result is streamed back byte-wise.
- Operand width, operand count and result length are parameters; per-command counts come from an external decode table. Adds timeout, error reporting and readout abort.

---
 rtl/herald_host_frontend.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/herald_host_frontend.sv
// Byte-serial host front end for Herald accelerators: captures a command and its operands, runs a
// valid/ready request/response exchange and streams the result back. `HERALD_TIMEOUT_EN adds an ISSUE/WAIT timeout.
module herald_host_frontend #(
  parameter int OP_BYTES       = 3,
  parameter int MAX_OPS        = 2,
  parameter int RES_BYTES_MAX  = 6,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        host_data_in,
  input  logic                              host_wr,
  input  logic                              host_rd,
  output logic [7:0]                        host_data_out,
  output logic                              host_busy,
  output logic                              host_err,
  output logic [7:0]                        cmd,
  input  logic [$clog2(MAX_OPS+1)-1:0]      cmd_nops,
  input  logic [$clog2(RES_BYTES_MAX+1)-1:0] cmd_nres,
  output logic [MAX_OPS*OP_BYTES*8-1:0]     operands,
  output logic                              req_valid,
  input  logic                              req_ready,
  input  logic                              rsp_valid,
  output logic                              rsp_ready,
  input  logic [RES_BYTES_MAX*8-1:0]        rsp_data
);

  localparam int NOPS_W = $clog2(MAX_OPS+1);
  localparam int NRES_W = $clog2(RES_BYTES_MAX+1);
  localparam int OI_W   = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;
  localparam int BC_W   = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
  localparam int RI_W   = (RES_BYTES_MAX > 1) ? $clog2(RES_BYTES_MAX) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(OP_BYTES-1);

  typedef enum logic [2:0] {IDLE, DECODE, OPERANDS, ISSUE, WAIT, READOUT} state_t;

  state_t state, state_n;
  logic [MAX_OPS-1:0][OP_BYTES-1:0][7:0] ops_q, ops_n;
  logic [RES_BYTES_MAX-1:0][7:0]         result, result_n;
  logic [7:0]       cmd_n, data_out_n;
  logic [OI_W-1:0]  op_idx, op_idx_n;
  logic [BC_W-1:0]  byte_cnt, byte_cnt_n;
  logic [RI_W-1:0]  rd_cnt, rd_cnt_n;
  logic [NOPS_W-1:0] nops_q, nops_n;
  logic [NRES_W-1:0] nres_q, nres_n;
  logic host_err_n, req_valid_n, rsp_ready_n;
  logic wr_prev, rd_prev, wr_edge, rd_edge, new_cmd;

  assign wr_edge  = host_wr & ~wr_prev;
  assign rd_edge  = host_rd & ~rd_prev;
  assign new_cmd  = wr_edge && (state == IDLE || state == READOUT);
  assign operands = ops_q;

`ifdef HERALD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES-1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] tmo_cnt, tmo_cnt_n;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_n     = state;
    cmd_n       = cmd;
    ops_n       = ops_q;
    result_n    = result;
    data_out_n  = host_data_out;
    op_idx_n    = op_idx;
    byte_cnt_n  = byte_cnt;
    rd_cnt_n    = rd_cnt;
    nops_n      = nops_q;
    nres_n      = nres_q;
    host_err_n  = host_err;
    req_valid_n = req_valid;
    rsp_ready_n = rsp_ready;
    // A write during readout abandons the remaining bytes and starts a fresh command.
    if (new_cmd) begin
      cmd_n      = host_data_in;
      ops_n      = '0;
      op_idx_n   = '0;
      byte_cnt_n = '0;
      host_err_n = 1'b0;
      state_n    = DECODE;
    end else begin
      case (state)
        DECODE: begin
          nops_n = cmd_nops;
          nres_n = cmd_nres;
          if (cmd_nops > NOPS_W'(MAX_OPS) || cmd_nres > NRES_W'(RES_BYTES_MAX)) begin
            host_err_n = 1'b1;
            state_n    = IDLE;
          end else if (cmd_nops == '0) begin
            req_valid_n = 1'b1;
            state_n     = ISSUE;
          end else begin
            state_n = OPERANDS;
          end
        end
        OPERANDS: if (wr_edge) begin
          ops_n[op_idx][byte_cnt] = host_data_in;
          if (byte_cnt == BC_LAST) begin
            byte_cnt_n = '0;
            op_idx_n   = op_idx + OI_W'(1);
            if (NOPS_W'(op_idx) == nops_q - NOPS_W'(1)) begin
              req_valid_n = 1'b1;
              state_n     = ISSUE;
            end
          end else begin
            byte_cnt_n = byte_cnt + BC_W'(1);
          end
        end
        ISSUE: if (req_ready) begin
          req_valid_n = 1'b0;
          rsp_ready_n = 1'b1;
          state_n     = WAIT;
        end
        WAIT: if (rsp_valid) begin
          result_n    = rsp_data;
          rd_cnt_n    = '0;
          rsp_ready_n = 1'b0;
          state_n     = (nres_q == '0) ? IDLE : READOUT;
        end
        READOUT: if (rd_edge) begin
          data_out_n = result[rd_cnt];
          rd_cnt_n   = rd_cnt + RI_W'(1);
          if (NRES_W'(rd_cnt) + NRES_W'(1) == nres_q)
            state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
`ifdef HERALD_TIMEOUT_EN
    tmo_cnt_n = tmo_cnt;
    if (state == ISSUE || state == WAIT)
      tmo_cnt_n = (tmo_cnt == TO_MAX) ? tmo_cnt : tmo_cnt + TO_W'(1);
    if (state_n == ISSUE && state != ISSUE)
      tmo_cnt_n = '0;
    // Only abort when no handshake moved us forward this cycle.
    if ((state == ISSUE || state == WAIT) && state_n == state && tmo_cnt >= TO_LAST) begin
      req_valid_n = 1'b0;
      rsp_ready_n = 1'b0;
      host_err_n  = 1'b1;
      state_n     = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd           <= '0;
      ops_q         <= '0;
      result        <= '0;
      host_data_out <= '0;
      op_idx        <= '0;
      byte_cnt      <= '0;
      rd_cnt        <= '0;
      nops_q        <= '0;
      nres_q        <= '0;
      host_err      <= 1'b0;
      host_busy     <= 1'b0;
      req_valid     <= 1'b0;
      rsp_ready     <= 1'b0;
      wr_prev       <= 1'b0;
      rd_prev       <= 1'b0;
`ifdef HERALD_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      state         <= state_n;
      cmd           <= cmd_n;
      ops_q         <= ops_n;
      result        <= result_n;
      host_data_out <= data_out_n;
      op_idx        <= op_idx_n;
      byte_cnt      <= byte_cnt_n;
      rd_cnt        <= rd_cnt_n;
      nops_q        <= nops_n;
      nres_q        <= nres_n;
      host_err      <= host_err_n;
      host_busy     <= (state_n != IDLE) && (state_n != READOUT);
      req_valid     <= req_valid_n;
      rsp_ready     <= rsp_ready_n;
      wr_prev       <= host_wr;
      rd_prev       <= host_rd;
`ifdef HERALD_TIMEOUT_EN
      tmo_cnt       <= tmo_cnt_n;
`endif
    end
  end

endmodule
